// File: rtl/dtree_feature_sequencer.sv
// Byte-serial feature framer for a combinational decision tree: assembles a frame,
// holds it on feat_bus, waits for the tree to settle and returns the sampled class.
module dtree_feature_sequencer #(
   parameter int NUM_FEAT   = 5,
   parameter int FEAT_W     = 8,
   parameter int CLASS_W    = 5,
   parameter int SETTLE_CYC = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [FEAT_W-1:0]            s_data,
   input  logic                         s_last,
   output logic [NUM_FEAT*FEAT_W-1:0]   feat_bus,
   input  logic [CLASS_W-1:0]           cls_in,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [CLASS_W-1:0]           m_class,
   output logic                         err_frame,
   output logic                         busy
);

   localparam int IDX_W = $clog2(NUM_FEAT);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);
   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {COLLECT, DRAIN, SETTLE, OUTPUT} state_t;

   state_t                        state_q, state_nxt;
   logic [IDX_W-1:0]              idx;
   logic [FEAT_W-1:0]             staging [NUM_FEAT];
   logic [3:0]                    settle_cnt;
   logic [NUM_FEAT*FEAT_W-1:0]    frame_nxt;
   logic                          accept;
   logic                          at_last_idx;
   logic                          good_frame;
   logic                          short_frame;
   logic                          long_frame;

   assign s_ready     = (state_q == COLLECT) || (state_q == DRAIN);
   assign accept      = s_valid && s_ready;
   assign at_last_idx = (idx == LAST_IDX);
   assign busy        = (state_q != COLLECT) || (idx != '0);

   // The final beat goes straight onto the bus; it never lands in staging first.
   always_comb begin
      frame_nxt = '0;
      for (int k = 0; k < NUM_FEAT; k++)
         frame_nxt[k*FEAT_W +: FEAT_W] = (k == NUM_FEAT - 1) ? s_data : staging[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      good_frame  = 1'b0;
      short_frame = 1'b0;
      long_frame  = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (at_last_idx) begin
                  if (s_last) begin
                     good_frame = 1'b1;
                     state_nxt  = SETTLE;
                  end else begin
                     long_frame = 1'b1;
                     state_nxt  = DRAIN;
                  end
               end else if (s_last) begin
                  short_frame = 1'b1;
               end
            end
         end
         DRAIN:   if (accept && s_last) state_nxt = COLLECT;
         SETTLE:  if (settle_cnt == '0) state_nxt = OUTPUT;
         OUTPUT:  if (m_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
         feat_bus   <= '0;
         m_valid    <= 1'b0;
         m_class    <= '0;
         err_frame  <= 1'b0;
         for (int k = 0; k < NUM_FEAT; k++) staging[k] <= '0;
      end else begin
         err_frame <= short_frame || long_frame;

         if (state_q == COLLECT && accept) begin
            staging[idx] <= s_data;
            idx          <= (s_last || at_last_idx) ? '0 : idx + IDX_W'(1);
         end

         if (good_frame) begin
            feat_bus   <= frame_nxt;
            settle_cnt <= SETTLE_LOAD;
         end else if (state_q == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end

         // Class is captured on the last settle cycle and held until taken.
         if (state_q == SETTLE && settle_cnt == '0) begin
            m_class <= cls_in;
            m_valid <= 1'b1;
         end else if (state_q == OUTPUT && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Randomized scoreboard bench for dtree_feature_sequencer with a frame-level reference model.
module tb_dtree_feature_sequencer;

   localparam int NUM_FEAT   = 5;
   localparam int FEAT_W     = 8;
   localparam int CLASS_W    = 5;
   localparam int SETTLE_CYC = 2;
   localparam int FB_W       = NUM_FEAT * FEAT_W;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 s_valid;
   logic                 s_ready;
   logic [FEAT_W-1:0]    s_data;
   logic                 s_last;
   logic [FB_W-1:0]      feat_bus;
   logic [CLASS_W-1:0]   cls_in;
   logic                 m_valid;
   logic                 m_ready;
   logic [CLASS_W-1:0]   m_class;
   logic                 err_frame;
   logic                 busy;

   logic [CLASS_W-1:0]   cls_mask = '0;

   dtree_feature_sequencer #(
      .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .feat_bus(feat_bus), .cls_in(cls_in), .m_valid(m_valid),
      .m_ready(m_ready), .m_class(m_class), .err_frame(err_frame), .busy(busy)
   );

   // Stand-in for the printed tree: purely combinational from the feature bus.
   assign cls_in = feat_bus[4:0] ^ feat_bus[36:32] ^ cls_mask;

   always #5 clk = ~clk;

   typedef struct {
      int                 t_acc;
      logic [CLASS_W-1:0] cls;
   } exp_t;

   exp_t               sb[$];
   logic [FB_W-1:0]    exp_feat = '0;
   logic [FEAT_W-1:0]  fdata [16];
   int                 cyc = 0;
   int                 checks = 0;
   int                 errors = 0;
   int                 err_exp = 0;
   int                 err_seen = 0;
   int                 mode = 0;
   int                 last_len = 0;
   int                 mv_cycles = 0;
   bit                 prev_mv = 1'b0;
   bit                 srdy_next = 1'b0;
   logic [CLASS_W-1:0] held_cls = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // m_ready policy: 0 always ready, 1 random, 2 hold off 10 cycles per result, 3 never.
   initial begin
      int hold;
      hold = 0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            2: begin
               if (m_valid && hold < 10) begin
                  m_ready = 1'b0;
                  hold++;
               end else if (m_valid) begin
                  m_ready = 1'b1;
               end else begin
                  m_ready = 1'b0;
                  hold = 0;
               end
            end
            default: m_ready = 1'b0;
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_mv   = 1'b0;
         mv_cycles = 0;
         srdy_next = 1'b0;
      end else begin
         chk("feat_bus", feat_bus, exp_feat);
         if (srdy_next) begin
            chk("s_ready_after_handshake", s_ready, 1);
            srdy_next = 1'b0;
         end
         if (m_valid) begin
            mv_cycles++;
            if (!prev_mv) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_m_valid: got 1 expected 0");
               end else begin
                  chk("latency", 64'(cyc - sb[0].t_acc), 64'(SETTLE_CYC));
                  chk("m_class", m_class, sb[0].cls);
               end
               held_cls = m_class;
            end else begin
               chk("m_class_hold", m_class, held_cls);
               chk("s_ready_in_output", s_ready, 0);
            end
            if (m_ready) begin
               if (sb.size() > 0) void'(sb.pop_front());
               last_len  = mv_cycles;
               mv_cycles = 0;
               srdy_next = 1'b1;
            end
         end
         if (err_frame) err_seen++;
         prev_mv = m_valid;
      end
   end

   task automatic send_beat(input logic [FEAT_W-1:0] d, input logic l, input bit gaps);
      int w;
      w = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      forever begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         w++;
         if (w > 500) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_ready expected s_ready within 500 cycles");
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Frame-level model: exactly NUM_FEAT beats is a frame, anything else is one error.
   task automatic send_frame(input int len, input bit gaps, input bit mask_sw);
      exp_t               e;
      logic [FB_W-1:0]    f;
      logic [CLASS_W-1:0] new_mask;
      for (int i = 0; i < len; i++) send_beat(fdata[i], (i == len - 1), gaps);
      if (len == NUM_FEAT) begin
         for (int k = 0; k < NUM_FEAT; k++) f[k*FEAT_W +: FEAT_W] = fdata[k];
         exp_feat = f;
         e.t_acc  = cyc;
         if (mask_sw) begin
            new_mask = 5'($urandom);
            e.cls    = fdata[0][4:0] ^ fdata[NUM_FEAT-1][4:0] ^ new_mask;
            sb.push_back(e);
            cls_mask = ~new_mask;
            repeat (SETTLE_CYC - 1) begin
               @(posedge clk);
               #1;
            end
            cls_mask = new_mask;
         end else begin
            e.cls = fdata[0][4:0] ^ fdata[NUM_FEAT-1][4:0] ^ cls_mask;
            sb.push_back(e);
         end
      end else begin
         err_exp++;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((sb.size() != 0 || m_valid) && w < 400) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 400) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got %0d pending results expected 0", sb.size());
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_frame_data();
      for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom);
   endtask

   task automatic do_reset(input string tag);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_class"}, m_class, 0);
      chk({tag, "_feat_bus"}, feat_bus, 0);
      chk({tag, "_err_frame"}, err_frame, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_s_ready"}, s_ready, 1);
      sb.delete();
      exp_feat = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      mode    = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_feat_bus", feat_bus, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err_frame", err_frame, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33; fdata[3] = 8'h44; fdata[4] = 8'h55;
      send_frame(5, 1'b0, 1'b0);
      wait_idle();
      chk("tp1_feat_bus", feat_bus, 40'h5544332211);
      chk("tp1_m_class", m_class, 5'h04);
      chk("tp1_m_valid_len", last_len, 1);
      chk("tp1_busy", busy, 0);

      mode = 2;
      send_frame(5, 1'b0, 1'b0);
      wait_idle();
      chk("tp2_m_valid_len", last_len, 11);
      chk("tp2_m_class", m_class, 5'h04);
      mode = 0;

      rand_frame_data();
      send_frame(3, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("short_err_count", err_seen, err_exp);
      chk("short_feat_kept", feat_bus, 40'h5544332211);
      chk("short_busy", busy, 0);
      rand_frame_data();
      send_frame(5, 1'b0, 1'b0);
      wait_idle();

      rand_frame_data();
      send_frame(7, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("long_err_count", err_seen, err_exp);
      chk("long_busy", busy, 0);
      rand_frame_data();
      send_frame(5, 1'b1, 1'b0);
      wait_idle();

      rand_frame_data();
      send_frame(5, 1'b0, 1'b1);
      wait_idle();

      rand_frame_data();
      send_beat(fdata[0], 1'b0, 1'b0);
      send_beat(fdata[1], 1'b0, 1'b0);
      chk("midframe_busy", busy, 1);
      do_reset("rst_mid");
      rand_frame_data();
      send_frame(5, 1'b0, 1'b0);
      wait_idle();

      mode = 3;
      rand_frame_data();
      send_frame(5, 1'b0, 1'b0);
      w = 0;
      while (!m_valid && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("output_reached", m_valid, 1);
      do_reset("rst_out");
      mode = 0;
      rand_frame_data();
      send_frame(5, 1'b0, 1'b0);
      wait_idle();

      mode = 1;
      for (int n = 0; n < 40; n++) begin
         int len;
         rand_frame_data();
         len = ($urandom_range(0, 9) < 7) ? NUM_FEAT : int'($urandom_range(1, NUM_FEAT + 3));
         send_frame(len, 1'b1, ($urandom_range(0, 3) == 0));
      end
      wait_idle();
      chk("final_pending", sb.size(), 0);
      chk("final_err_count", err_seen, err_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
